uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// UART with TX/RX byte FIFOs behind a valid/ready memory bus, 8N1 framing, programmable divisor.
// Define UART_FLOWCTL_EN to gate TX on ser_cts and drive ser_rts from RX FIFO space.
module uart_fifo #(
  parameter logic [31:0] ADDR        = 32'hffff_ffff,
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        uart_ready,
  output logic        uart_sel,
  output logic [31:0] uart_rdata,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic        ser_cts,
  output logic        ser_rts
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] T_ONE = 1;
  localparam logic [RAW:0] R_ONE = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  logic [1:0] rx_sync, cts_sync;
  logic       rx_prev, rx_s, cts_s, cts_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      cts_sync <= 2'b11;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync  <= {rx_sync[0], ser_rx};
      cts_sync <= {cts_sync[0], ser_cts};
      rx_prev  <= rx_sync[1];
    end
  assign rx_s  = rx_sync[1];
  assign cts_s = cts_sync[1];

  logic sel_div, sel_data, sel_stat, sel_ctrl, wr;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic div_we, clr, flush, rx_done, ferr_set, overrun, ferr, tx_busy;
  logic [31:0] div_q, eff_div;

  assign sel_div  = mem_addr == ADDR;
  assign sel_data = mem_addr == ADDR + 32'd4;
  assign sel_stat = mem_addr == ADDR + 32'd8;
  assign sel_ctrl = mem_addr == ADDR + 32'd12;
  assign uart_sel = mem_valid && (sel_div || sel_data || sel_stat || sel_ctrl);
  assign wr       = |mem_wstrb;
  // A full TX FIFO still accepts the write in a cycle where the FSM pops.
  assign uart_ready = uart_sel && !(sel_data && wr && tx_full && !tx_pop);
  assign tx_push  = uart_ready && sel_data && wr;
  assign rx_pop   = uart_ready && sel_data && !wr && !rx_empty;
  assign div_we   = uart_ready && sel_div && wr;
  assign clr      = uart_ready && sel_ctrl && wr && mem_wdata[0];
  assign flush    = uart_ready && sel_ctrl && wr && mem_wdata[1];
  assign eff_div  = (div_q < 32'd4) ? 32'd4 : div_q;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp, tx_used;
  assign tx_used  = tx_wp - tx_rp;
  assign tx_full  = tx_used == (TAW+1)'(TX_DEPTH);
  assign tx_empty = tx_used == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + T_ONE;
      if (tx_pop)  tx_rp <= tx_rp + T_ONE;
    end
  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= mem_wdata[7:0];

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp, rx_rp, rx_used;
  logic [7:0]   rx_sh, rx_sh_d;
  assign rx_used  = rx_wp - rx_rp;
  assign rx_full  = rx_used == (RAW+1)'(RX_DEPTH);
  assign rx_empty = rx_used == '0;
  assign rx_push  = rx_done && (!rx_full || rx_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + R_ONE;
      if (rx_pop)  rx_rp <= rx_rp + R_ONE;
    end
  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh_d;

`ifdef UART_FLOWCTL_EN
  assign cts_ok  = !cts_s;
  assign ser_rts = !rst_n || (rx_used >= (RAW+1)'(RX_DEPTH-1));
`else
  assign cts_ok  = 1'b1;
  assign ser_rts = !rst_n;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q   <= DEFAULT_DIV;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (div_we && mem_wstrb[i]) div_q[8*i +: 8] <= mem_wdata[8*i +: 8];
      if (clr) begin
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end
      if (rx_done && rx_full && !rx_pop) overrun <= 1'b1;
      if (ferr_set) ferr <= 1'b1;
    end

  // TX: divisor is latched at frame start so a DIV write never disturbs a frame in flight.
  uart_state_t tx_state, tx_state_d;
  logic [31:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_sh, tx_sh_d;
  logic        tx_q, tx_d, tx_end;
  assign tx_pop  = (tx_state == IDLE) && !tx_empty && cts_ok;
  assign tx_end  = tx_cnt == tx_div - 32'd1;
  assign tx_busy = tx_state != IDLE;
  assign ser_tx  = tx_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_div   <= tx_div_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_q     <= tx_d;
    end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 32'd1;
    tx_div_d   = tx_div;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_d       = tx_q;
    case (tx_state)
      IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_pop) begin
          tx_state_d = START;
          tx_div_d   = eff_div;
          tx_sh_d    = tx_mem[tx_rp[TAW-1:0]];
          tx_d       = 1'b0;
        end
      end
      START: if (tx_end) begin
        tx_state_d = DATA;
        tx_cnt_d   = '0;
        tx_d       = tx_sh[0];
      end
      DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit + 3'd1;
        tx_sh_d  = {1'b0, tx_sh[7:1]};
        tx_d     = tx_sh[1];
        if (tx_bit == 3'd7) begin
          tx_state_d = STOP;
          tx_d       = 1'b1;
        end
      end
      STOP: if (tx_end) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  // RX: START waits half a bit, so every later DIV-spaced sample lands mid-bit.
  uart_state_t rx_state, rx_state_d;
  logic [31:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic        rx_end, rx_half;
  assign rx_end  = rx_cnt == rx_div - 32'd1;
  assign rx_half = rx_cnt == (rx_div >> 1) - 32'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_div   <= DEFAULT_DIV;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_div   <= rx_div_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
    end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 32'd1;
    rx_div_d   = rx_div;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_s) begin
          rx_state_d = START;
          rx_div_d   = eff_div;
        end
      end
      START: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh[7:1]};
        rx_bit_d = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_d = STOP;
      end
      STOP: if (rx_end) begin
        rx_state_d = IDLE;
        rx_done    = rx_s;
        ferr_set   = !rx_s;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_rdata = '0;
    if (uart_sel) begin
      if (sel_div)       uart_rdata = div_q;
      else if (sel_data) uart_rdata = rx_empty ? 32'hffff_ffff : {24'h0, rx_mem[rx_rp[RAW-1:0]]};
      else if (sel_stat) uart_rdata = {25'h0, ferr, cts_s, tx_busy, overrun, rx_empty, tx_empty, tx_full};
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: bus registers, TX framing and stalls, RX overrun/framing, flow control, reset.
module tb_uart_fifo;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] A_DIV = BASE, A_DATA = BASE + 32'd4, A_STAT = BASE + 32'd8, A_CTRL = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        uart_ready, uart_sel, ser_tx, ser_rts;
  logic [31:0] uart_rdata;
  logic        ser_rx = 1'b1;
  logic        ser_cts = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];
  int mon_div = 8;
  bit mon_en = 0;

  uart_fifo #(.ADDR(BASE), .TX_DEPTH(4), .RX_DEPTH(4), .DEFAULT_DIV(32'd104)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .uart_ready(uart_ready),
    .uart_sel(uart_sel), .uart_rdata(uart_rdata), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .ser_cts(ser_cts), .ser_rts(ser_rts)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int stall);
    stall = 0;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    @(negedge clk);
    while (!uart_ready && stall < 5000) begin stall++; @(negedge clk); end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = '0;
    @(negedge clk);
    while (!uart_ready && n < 1000) begin n++; @(negedge clk); end
    d = uart_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin ser_rx = f[i]; repeat (div) @(posedge clk); #1; end
    ser_rx = 1'b1;
    repeat (div) @(posedge clk); #1;
  endtask

  task automatic wait_txq(input int n, input int budget);
    int c = 0;
    while (txq.size() < n && c < budget) begin @(negedge clk); c++; end
    @(posedge clk); #1;
  endtask

  // Line monitor: samples each bit of ser_tx at its midpoint.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && ser_tx === 1'b0) begin
        repeat (mon_div / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin repeat (mon_div) @(negedge clk); b[k] = ser_tx; end
        repeat (mon_div) @(negedge clk);
        txq.push_back(b);
      end
    end
  end

  initial begin
    logic [31:0] rd;
    int st [6];
    logic tx_log [200];
    logic busy_log [200];
    logic [7:0] bytes3 [6];
    int s, busy_n, zrun, lows, n;
    logic [9:0] bits;
    logic rts_exp;

    bytes3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5a, 8'hc3};

    repeat (3) @(posedge clk); #1;
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_ser_rts", ser_rts, 1);
    chk("rst_rdata_idle", uart_rdata, 0);
    resetn = 1'b1;
    repeat (5) @(posedge clk); #1;
    mon_en = 1;
    chk("rts_after_rst", ser_rts, 0);
    bus_rd(A_STAT, rd); chk("status_rst", rd, 32'h06);
    bus_rd(A_DIV, rd);  chk("div_rst", rd, 32'd104);
    bus_rd(A_DATA, rd); chk("data_empty", rd, 32'hffff_ffff);
    bus_rd(A_CTRL, rd); chk("ctrl_rd", rd, 32'h0);
    mem_valid = 1'b1; mem_addr = BASE + 32'd16; #1;
    chk("sel_unmapped", uart_sel, 0);
    chk("rdata_unmapped", uart_rdata, 0);
    mem_valid = 1'b0;
    @(posedge clk); #1;

    // 0x55 at DIV=8, watching ser_tx and tx_busy every cycle
    mon_div = 8;
    bus_wr(A_DIV, 32'd8, 4'hf, st[0]);
    bus_wr(A_DATA, 32'h55, 4'h1, st[0]);
    mem_valid = 1'b1; mem_addr = A_STAT; mem_wstrb = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tx_log[i] = ser_tx;
      busy_log[i] = uart_rdata[4];
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    s = -1; busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (s < 0 && tx_log[i] == 1'b0) s = i;
      if (busy_log[i]) busy_n++;
    end
    chk("tx55_start_found", (s >= 0 && s <= 100), 1);
    if (s < 0 || s > 100) s = 0;
    zrun = 0;
    while (zrun < 20 && tx_log[s + zrun] == 1'b0) zrun++;
    for (int k = 0; k < 10; k++) bits[k] = tx_log[s + 4 + 8 * k];
    chk("tx55_bits", {22'h0, bits}, 32'h2aa);
    chk("tx55_start_len", zrun, 8);
    chk("tx55_busy_clks", busy_n, 80);
    chk("tx55_mon_cnt", txq.size(), 1);
    if (txq.size() > 0) chk("tx55_mon_byte", txq[0], 8'h55);
    txq.delete();

    // back-to-back writes into a 4-deep TX FIFO at DIV=16
    mon_div = 16;
    bus_wr(A_DIV, 32'd16, 4'h1, st[0]);
    bus_rd(A_DIV, rd); chk("div16_rd", rd, 32'd16);
    for (int i = 0; i < 6; i++) bus_wr(A_DATA, {24'h0, bytes3[i]}, 4'h1, st[i]);
    chk("wr1to5_nostall", st[0] + st[1] + st[2] + st[3] + st[4], 0);
    chk("wr6_stalls", (st[5] >= 100 && st[5] <= 200), 1);
    wait_txq(6, 1500);
    chk("tx6_count", txq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < txq.size()) chk($sformatf("tx6_byte%0d", i), txq[i], bytes3[i]);
    txq.delete();
    repeat (40) @(posedge clk); #1;

    // RX overrun with a 4-deep RX FIFO
    for (int i = 0; i < 5; i++) send_rx(8'ha0 + 8'(i), 1'b1, 16);
    repeat (20) @(posedge clk); #1;
    bus_rd(A_STAT, rd); chk("status_overrun", rd, 32'h0a);
`ifdef UART_FLOWCTL_EN
    rts_exp = 1'b1;
`else
    rts_exp = 1'b0;
`endif
    chk("rts_rx_full", ser_rts, rts_exp);
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_DATA, rd);
      chk($sformatf("rx_byte%0d", i), rd, 32'ha0 + i);
    end
    bus_rd(A_DATA, rd); chk("rx_empty_read", rd, 32'hffff_ffff);
    chk("rts_rx_empty", ser_rts, 0);
    bus_rd(A_STAT, rd); chk("status_ovr_empty", rd, 32'h0e);

    // framing error, clear, good frame, flush
    send_rx(8'h3c, 1'b0, 16);
    repeat (20) @(posedge clk); #1;
    bus_rd(A_STAT, rd); chk("status_ferr", rd, 32'h4e);
    bus_rd(A_DATA, rd); chk("ferr_no_entry", rd, 32'hffff_ffff);
    bus_wr(A_CTRL, 32'h1, 4'h1, st[0]);
    bus_rd(A_STAT, rd); chk("status_cleared", rd, 32'h06);
    send_rx(8'h96, 1'b1, 16);
    repeat (20) @(posedge clk); #1;
    bus_rd(A_DATA, rd); chk("rx_0x96", rd, 32'h96);
    send_rx(8'h5a, 1'b1, 16);
    repeat (20) @(posedge clk); #1;
    bus_wr(A_CTRL, 32'h2, 4'h1, st[0]);
    bus_rd(A_STAT, rd); chk("status_flushed", rd, 32'h06);

    // clear-to-send handling
    ser_cts = 1'b1;
    repeat (4) @(posedge clk); #1;
    bus_rd(A_STAT, rd); chk("status_cts", rd, 32'h26);
    bus_wr(A_DATA, 32'h81, 4'h1, st[0]);
    lows = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!ser_tx) lows++; end
    @(posedge clk); #1;
`ifdef UART_FLOWCTL_EN
    chk("cts_holds_tx", lows, 0);
    ser_cts = 1'b0;
    n = 0;
    @(negedge clk); n++;
    while (ser_tx && n < 20) begin @(negedge clk); n++; end
    chk("cts_start_lat", (n <= 4 && !ser_tx), 1);
    @(posedge clk); #1;
`else
    chk("cts_no_gate", (lows > 0), 1);
`endif
    wait_txq(1, 400);
    chk("cts_frame_cnt", txq.size(), 1);
    if (txq.size() > 0) chk("cts_frame_byte", txq[0], 8'h81);
    ser_cts = 1'b1;
    repeat (20) @(posedge clk); #1;

    // reset in the middle of a frame
    mon_en = 0;
    ser_cts = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus_wr(A_DATA, 32'h00, 4'h1, st[0]);
    n = 0;
    @(negedge clk);
    while (ser_tx && n < 50) begin @(negedge clk); n++; end
    chk("rst_frame_started", ser_tx, 0);
    repeat (20) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_midframe_tx", ser_tx, 1);
    chk("rst_midframe_rts", ser_rts, 1);
    ser_cts = 1'b1;
    repeat (3) @(posedge clk); #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk); #1;
    bus_rd(A_STAT, rd); chk("status_after_rst", rd, 32'h06 | (32'(ser_cts) << 5));
    bus_rd(A_DIV, rd);  chk("div_after_rst", rd, 32'd104);
    chk("tx_idle_after_rst", ser_tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
